ika2151_timer_channel: RTL and testbench

- One YM2151-style interval timer channel: prescaled tick, up-counter with preload, overflow reload, and a sticky status flag for IRQ.
- Sits directly downstream of the shared cycle-counter primitive. The counter primitive is instantiated inside this block; its carry output drives reload, overflow pulse and flag logic.
- Two instances in the timer section:
  - Timer A: WIDTH=10, PRESCALE=1.
  - Timer B: WIDTH=8, PRESCALE=16.

---
 rtl/ika2151_pkg.sv | 22 ++
 rtl/primitive_counter.sv | 56 +++++
 rtl/ika2151_timer_channel.sv | 125 ++++++++++++
 tb/tb_ika2151_timer_channel.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ika2151_pkg.sv
// ika2151_pkg
// Shared constants for the YM2151-style timer section.
//   TMRA_WIDTH / TMRA_PRESCALE : timer A counter width and ticks per increment
//   TMRB_WIDTH / TMRB_PRESCALE : timer B counter width and ticks per increment
//   prescaleWidth()            : bits needed to hold a prescaler count 0..p-1
package ika2151_pkg;

    localparam int TMRA_WIDTH    = 10;
    localparam int TMRA_PRESCALE = 1;
    localparam int TMRB_WIDTH    = 8;
    localparam int TMRB_PRESCALE = 16;

    // A prescale of 1 still needs a one-bit register so the code stays uniform;
    // that bit simply never leaves 0.
    function automatic int prescaleWidth(input int p);
        if (p <= 2) begin
            return 1;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/primitive_counter.sv
// primitive_counter
// Shared cycle-counter primitive: synchronous clear, load and increment, all
// qualified by the positive-phase enable, plus an asynchronous clear.
//   i_EMUCLK : master clock
//   i_RST_n  : asynchronous active-low clear
//   i_PCEN_n : positive-phase clock enable, active low
//   i_RST    : synchronous clear (highest priority)
//   i_LD     : load i_D
//   i_CNT    : increment by one
//   i_D      : load value
//   o_Q      : counter value
//   o_CO     : carry, high when counting from all-ones
module primitive_counter #(
    parameter int WIDTH = 10
) (
    input  logic             i_EMUCLK,
    input  logic             i_RST_n,
    input  logic             i_PCEN_n,
    input  logic             i_RST,
    input  logic             i_LD,
    input  logic             i_CNT,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q,
    output logic             o_CO
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Carry is combinational so the owner can use it to reload on the very
    // same edge that would otherwise wrap the counter.
    assign o_CO = i_CNT & (&cnt_q);
    assign o_Q  = cnt_q;

    // Clear beats load, load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (i_RST) begin
            cnt_d = '0;
        end else if (i_LD) begin
            cnt_d = i_D;
        end else if (i_CNT) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // State only moves on the positive phase; the async clear wins at any time.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            cnt_q <= '0;
        end else if (!i_PCEN_n) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ika2151_timer_channel.sv
// ika2151_timer_channel
// One interval timer channel: prescaled tick, preloadable up-counter that
// reloads on overflow, one-period overflow strobe and a sticky IRQ flag.
//   i_EMUCLK   : master clock, all flops on posedge
//   i_IC_n     : asynchronous active-low reset
//   i_PCEN_n   : positive-phase enable (counter, o_OVFL, o_FLAG)
//   i_NCEN_n   : negative-phase enable (input sampling, prescaler, count enable)
//   i_TICK     : one-cycle sample tick
//   i_LOAD_VAL : preload / reload value
//   i_RUN      : run enable; low keeps the counter loaded
//   i_FLAG_EN  : allow overflow to set o_FLAG
//   i_FLAG_RST : clear o_FLAG (level, wins over a set)
//   o_CNT      : current counter value (straight from the counter primitive)
//   o_OVFL     : overflow strobe, one PCEN period wide
//   o_FLAG     : sticky overflow flag
module ika2151_timer_channel
    import ika2151_pkg::*;
#(
    parameter int WIDTH    = TMRA_WIDTH,
    parameter int PRESCALE = TMRA_PRESCALE
) (
    input  logic             i_EMUCLK,
    input  logic             i_IC_n,
    input  logic             i_PCEN_n,
    input  logic             i_NCEN_n,
    input  logic             i_TICK,
    input  logic [WIDTH-1:0] i_LOAD_VAL,
    input  logic             i_RUN,
    input  logic             i_FLAG_EN,
    input  logic             i_FLAG_RST,
    output logic [WIDTH-1:0] o_CNT,
    output logic             o_OVFL,
    output logic             o_FLAG
);

    localparam int            PW      = prescaleWidth(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler_q;
    logic [PW-1:0] prescaler_d;
    logic          cntEn_q;
    logic          cntEn_d;
    logic          runSmp_q;
    logic          flagRstSmp_q;
    logic          ovfl_q;
    logic          flag_q;
    logic          flag_d;
    logic          carry;
    logic          counterLoad;

    // The prescaler sits at 0 while stopped so a restart always needs a full
    // PRESCALE ticks before the first increment. With PRESCALE=1 PRE_MAX is 0
    // and every tick produces a count enable.
    always_comb begin
        prescaler_d = prescaler_q;
        cntEn_d     = i_TICK & i_RUN & (prescaler_q == PRE_MAX);
        if (!i_RUN) begin
            prescaler_d = '0;
        end else if (i_TICK) begin
            prescaler_d = (prescaler_q == PRE_MAX) ? '0 : prescaler_q + PW'(1);
        end
    end

    // Negative-phase stage: sample the control inputs and advance the prescaler.
    // Run and count enable are captured on the same edge, so a stopped channel
    // can never carry.
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            prescaler_q  <= '0;
            cntEn_q      <= 1'b0;
            runSmp_q     <= 1'b0;
            flagRstSmp_q <= 1'b0;
        end else if (!i_NCEN_n) begin
            prescaler_q  <= prescaler_d;
            cntEn_q      <= cntEn_d;
            runSmp_q     <= i_RUN;
            flagRstSmp_q <= i_FLAG_RST;
        end
    end

    // Reload whenever stopped or on overflow, so the count never wraps
    // through zero unless the load value itself is zero.
    assign counterLoad = ~runSmp_q | carry;

    primitive_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .i_EMUCLK(i_EMUCLK),
        .i_RST_n (i_IC_n),
        .i_PCEN_n(i_PCEN_n),
        .i_RST   (1'b0),
        .i_LD    (counterLoad),
        .i_CNT   (cntEn_q),
        .i_D     (i_LOAD_VAL),
        .o_Q     (o_CNT),
        .o_CO    (carry)
    );

    // A pending clear overrides a simultaneous overflow set; otherwise the flag
    // holds regardless of what i_FLAG_EN does afterwards.
    always_comb begin
        flag_d = flag_q;
        if (flagRstSmp_q) begin
            flag_d = 1'b0;
        end else if (carry & i_FLAG_EN) begin
            flag_d = 1'b1;
        end
    end

    // Positive-phase stage: the strobe is refreshed every PCEN, which makes it
    // exactly one PCEN period wide.
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            ovfl_q <= 1'b0;
            flag_q <= 1'b0;
        end else if (!i_PCEN_n) begin
            ovfl_q <= carry;
            flag_q <= flag_d;
        end
    end

    assign o_OVFL = ovfl_q;
    assign o_FLAG = flag_q;

endmodule

// File: tb/tb_ika2151_timer_channel.sv
// tb_ika2151_timer_channel
// Directed bench for a timer A (10-bit, /1) and a timer B (8-bit, /16)
// channel sharing clock, reset, enables and control inputs.
module tb_ika2151_timer_channel;

    logic       clock;
    logic       icN;
    logic       pcenN;
    logic       ncenN;
    logic       tick;
    logic       run;
    logic       flagEn;
    logic       flagRst;
    logic [9:0] loadA;
    logic [7:0] loadB;
    logic [9:0] cntA;
    logic       ovflA;
    logic       flagA;
    logic [7:0] cntB;
    logic       ovflB;
    logic       flagB;

    int vectors;
    int miscompares;

    ika2151_timer_channel #(
        .WIDTH   (10),
        .PRESCALE(1)
    ) dutA (
        .i_EMUCLK  (clock),
        .i_IC_n    (icN),
        .i_PCEN_n  (pcenN),
        .i_NCEN_n  (ncenN),
        .i_TICK    (tick),
        .i_LOAD_VAL(loadA),
        .i_RUN     (run),
        .i_FLAG_EN (flagEn),
        .i_FLAG_RST(flagRst),
        .o_CNT     (cntA),
        .o_OVFL    (ovflA),
        .o_FLAG    (flagA)
    );

    ika2151_timer_channel #(
        .WIDTH   (8),
        .PRESCALE(16)
    ) dutB (
        .i_EMUCLK  (clock),
        .i_IC_n    (icN),
        .i_PCEN_n  (pcenN),
        .i_NCEN_n  (ncenN),
        .i_TICK    (tick),
        .i_LOAD_VAL(loadB),
        .i_RUN     (run),
        .i_FLAG_EN (flagEn),
        .i_FLAG_RST(flagRst),
        .o_CNT     (cntB),
        .o_OVFL    (ovflB),
        .o_FLAG    (flagB)
    );

    // Free-running master clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One NCEN edge with the given controls, then one PCEN edge. Inputs change
    // 1 time unit after each edge; outputs are read after the PCEN edge.
    task automatic applyStimulus(input logic tickIn, input logic runIn, input logic flagRstIn);
        tick    = tickIn;
        run     = runIn;
        flagRst = flagRstIn;
        ncenN   = 1'b0;
        pcenN   = 1'b1;
        @(posedge clock);
        #1;
        tick  = 1'b0;
        ncenN = 1'b1;
        pcenN = 1'b0;
        @(posedge clock);
        #1;
        pcenN = 1'b1;
    endtask

    // Compare one observed value against its hand-derived expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Pulse the asynchronous reset between test sections.
    task automatic pulseReset();
        icN = 1'b0;
        #2;
        icN = 1'b1;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        icN     = 1'b0;
        pcenN   = 1'b1;
        ncenN   = 1'b1;
        tick    = 1'b0;
        run     = 1'b0;
        flagEn  = 1'b0;
        flagRst = 1'b0;
        loadA   = '0;
        loadB   = '0;
        @(posedge clock);
        #1;
        checkOutput("reset cntA", 32'(cntA), 0);
        checkOutput("reset flagA", 32'(flagA), 0);
        icN = 1'b1;
        @(posedge clock);
        #1;

        // Timer A overflow: 1020 -> 1021, 1022, 1023, reload 1020 with strobe and flag.
        $display("[TB] timer A overflow");
        loadA  = 10'd1020;
        flagEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("A stopped load", 32'(cntA), 1020);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("A tick1 cnt", 32'(cntA), 1021);
        checkOutput("A tick1 ovfl", 32'(ovflA), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("A tick2 cnt", 32'(cntA), 1022);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("A tick3 cnt", 32'(cntA), 1023);
        checkOutput("A tick3 flag", 32'(flagA), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("A tick4 reload", 32'(cntA), 1020);
        checkOutput("A tick4 ovfl", 32'(ovflA), 1);
        checkOutput("A tick4 flag", 32'(flagA), 1);
        flagEn = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("A idle cnt", 32'(cntA), 1020);
        checkOutput("A strobe width", 32'(ovflA), 0);
        checkOutput("A flag sticky", 32'(flagA), 1);

        // Reset mid-run at 0x155: clears immediately, even while enables toggle.
        $display("[TB] reset mid-run");
        pulseReset();
        loadA = 10'h154;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("A pre-reset cnt", 32'(cntA), 32'h155);
        icN = 1'b0;
        #1;
        checkOutput("reset async cntA", 32'(cntA), 0);
        checkOutput("reset async ovflA", 32'(ovflA), 0);
        checkOutput("reset async flagA", 32'(flagA), 0);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("reset held cntA", 32'(cntA), 0);
        icN = 1'b1;
        #1;

        // Timer B prescale: 254 stays until tick 16, 255 until tick 32, then reload.
        $display("[TB] timer B prescale");
        pulseReset();
        loadB  = 8'd254;
        flagEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("B stopped load", 32'(cntB), 254);
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("B tick%0d cnt", k), 32'(cntB), (k >= 16 && k < 32) ? 255 : 254);
            checkOutput($sformatf("B tick%0d ovfl", k), 32'(ovflB), (k == 32) ? 1 : 0);
        end
        checkOutput("B flag", 32'(flagB), 1);

        // Clear held across an overflow wins; once released the next overflow sets.
        $display("[TB] flag priority");
        pulseReset();
        loadA  = 10'd1023;
        flagEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("prio ovfl", 32'(ovflA), 1);
        checkOutput("prio flag held clear", 32'(flagA), 0);
        checkOutput("prio cnt", 32'(cntA), 1023);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("prio ovfl2", 32'(ovflA), 1);
        checkOutput("prio flag set", 32'(flagA), 1);

        // Flag enable off with all-ones load: strobe every tick, flag never set.
        $display("[TB] flag enable off");
        pulseReset();
        loadA  = 10'd1023;
        flagEn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("noflag tick%0d ovfl", k), 32'(ovflA), 1);
            checkOutput($sformatf("noflag tick%0d flag", k), 32'(flagA), 0);
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("noflag gap%0d ovfl", k), 32'(ovflA), 0);
        end

        // Stop/restart: stopped counter follows the load value and ignores ticks.
        $display("[TB] stop and restart");
        pulseReset();
        loadA = 10'd5;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("stop load 5", 32'(cntA), 5);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("run from 5", 32'(cntA), 6);
        loadA = 10'd9;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("stop tracks 9", 32'(cntA), 9);
        checkOutput("stop no ovfl", 32'(ovflA), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("restart first inc", 32'(cntA), 10);

        // Load value changed while running is only used at the next overflow.
        $display("[TB] load change while running");
        pulseReset();
        loadA = 10'd1022;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("late load cnt", 32'(cntA), 1023);
        loadA = 10'd100;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("late load ignored", 32'(cntA), 1023);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("late load reload", 32'(cntA), 100);
        checkOutput("late load ovfl", 32'(ovflA), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
